// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that registers one finished FU result per cycle onto the common data bus.
// Optional conflict counter port enabled by defining CDB_PERF_EN.
module cdb_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ROB_IX_W = 3,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    input  logic [NUM_REQ*ROB_IX_W-1:0]   req_rob_ix_in,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data_in,
    output logic [NUM_REQ-1:0]            req_read_out,
    input  logic                          cdb_ready_in,
    input  logic                          flush_in,
    output logic                          cdb_valid_out,
    output logic [ROB_IX_W-1:0]           cdb_rob_ix_out,
    output logic [DATA_W-1:0]             cdb_value_out,
    output logic [$clog2(NUM_REQ)-1:0]    cdb_src_out
`ifdef CDB_PERF_EN
    ,
    output logic [31:0]                   conflict_cnt_out
`endif
);

    localparam int unsigned SRC_W = $clog2(NUM_REQ);

    logic                cdb_valid_q;
    logic [ROB_IX_W-1:0] cdb_rob_ix_q;
    logic [DATA_W-1:0]   cdb_value_q;
    logic [SRC_W-1:0]    cdb_src_q;
    logic [SRC_W-1:0]    prio_ptr_q, prio_ptr_d;

    logic                adv;
    logic [NUM_REQ-1:0]  grant;
    logic                grant_any;
    logic [SRC_W-1:0]    grant_ix;
    logic [ROB_IX_W-1:0] sel_rob_ix;
    logic [DATA_W-1:0]   sel_data;

    assign adv = !flush_in && (cdb_ready_in || !cdb_valid_q);

    // First requester at or after prio_ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_ix  = '0;
        if (adv && rst_n_in) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!grant_any && req_valid_in[(32'(prio_ptr_q) + k) % NUM_REQ]) begin
                    grant_any = 1'b1;
                    grant_ix  = SRC_W'((32'(prio_ptr_q) + k) % NUM_REQ);
                end
            end
            if (grant_any) begin
                grant[grant_ix] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_rob_ix = req_rob_ix_in[grant_ix*ROB_IX_W +: ROB_IX_W];
        sel_data   = req_data_in[grant_ix*DATA_W +: DATA_W];
        prio_ptr_d = (grant_ix == SRC_W'(NUM_REQ - 1)) ? '0 : grant_ix + 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cdb_valid_q  <= 1'b0;
            cdb_rob_ix_q <= '0;
            cdb_value_q  <= '0;
            cdb_src_q    <= '0;
            prio_ptr_q   <= '0;
        end else if (flush_in) begin
            cdb_valid_q <= 1'b0;
        end else if (adv) begin
            if (grant_any) begin
                cdb_valid_q  <= 1'b1;
                cdb_rob_ix_q <= sel_rob_ix;
                cdb_value_q  <= sel_data;
                cdb_src_q    <= grant_ix;
                prio_ptr_q   <= prio_ptr_d;
            end else begin
                cdb_valid_q <= 1'b0;
            end
        end
    end

    assign req_read_out   = grant;
    assign cdb_valid_out  = cdb_valid_q;
    assign cdb_rob_ix_out = cdb_rob_ix_q;
    assign cdb_value_out  = cdb_value_q;
    assign cdb_src_out    = cdb_src_q;

`ifdef CDB_PERF_EN
    logic [31:0] conflict_cnt_q;
    logic        multi_req;
    logic        conflict;

    // Two or more bits set iff clearing the lowest set bit leaves something.
    assign multi_req = |(req_valid_in & (req_valid_in - 1'b1));
    assign conflict  = adv ? multi_req : |req_valid_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            conflict_cnt_q <= '0;
        end else if (conflict && conflict_cnt_q != 32'hFFFF_FFFF) begin
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign conflict_cnt_out = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized bench for cdb_arbiter against a behavioural bus model.
module tb_cdb_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [11:0]  req_rob_ix;
    logic [127:0] req_data;
    logic [3:0]   req_read;
    logic         cdb_ready;
    logic         flush;
    logic         cdb_valid;
    logic [2:0]   cdb_rob_ix;
    logic [31:0]  cdb_value;
    logic [1:0]   cdb_src;
`ifdef CDB_PERF_EN
    logic [31:0]  conflict_cnt;
`endif

    cdb_arbiter #(.NUM_REQ(4), .ROB_IX_W(3), .DATA_W(32)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .req_valid_in   (req_valid),
        .req_rob_ix_in  (req_rob_ix),
        .req_data_in    (req_data),
        .req_read_out   (req_read),
        .cdb_ready_in   (cdb_ready),
        .flush_in       (flush),
        .cdb_valid_out  (cdb_valid),
        .cdb_rob_ix_out (cdb_rob_ix),
        .cdb_value_out  (cdb_value),
        .cdb_src_out    (cdb_src)
`ifdef CDB_PERF_EN
        ,
        .conflict_cnt_out (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model of the bus
    logic        m_valid;
    logic [2:0]  m_tag;
    logic [31:0] m_val;
    int          m_src;
    int          m_ptr;
    longint      m_cnt;

    logic [2:0]  fu_tag [4];
    logic [31:0] fu_data[4];
    logic [3:0]  last_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input logic [3:0] v, input logic rdy, input logic fl);
        if (fl || !(rdy || !m_valid)) return -1;
        for (int k = 0; k < 4; k++) begin
            if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_tag = '0; m_val = '0; m_src = 0; m_ptr = 0; m_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"}, 32'(cdb_valid), 32'(m_valid));
        chk({tag, "_tag"}, 32'(cdb_rob_ix), 32'(m_tag));
        chk({tag, "_value"}, cdb_value, m_val);
        chk({tag, "_src"}, 32'(cdb_src), 32'(m_src));
`ifdef CDB_PERF_EN
        chk({tag, "_cnt"}, conflict_cnt, 32'(m_cnt));
`endif
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic step(input string tag, input logic [3:0] v, input logic rdy, input logic fl);
        int w;
        logic [3:0] exp_g;
        req_valid = v; cdb_ready = rdy; flush = fl;
        for (int n = 0; n < 4; n++) begin
            req_rob_ix[n*3 +: 3]  = fu_tag[n];
            req_data[n*32 +: 32] = fu_data[n];
        end
        #2;
        w = winner(v, rdy, fl);
        exp_g = (w < 0) ? 4'b0000 : 4'(1 << w);
        chk({tag, "_grant"}, 32'(req_read), 32'(exp_g));
        last_grant = req_read;
        @(posedge clk);
        if ((fl || !(rdy || !m_valid)) ? (v != 0) : ($countones(v) >= 2)) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end
        if (fl) begin
            m_valid = 1'b0;
        end else if (rdy || !m_valid) begin
            if (w >= 0) begin
                m_valid = 1'b1; m_tag = fu_tag[w]; m_val = fu_data[w];
                m_src = w; m_ptr = (w + 1) % 4;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check_outputs(tag);
    endtask

    // Asynchronous reset asserted mid-cycle with a request present.
    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 4'b1011;
        #2;
        model_reset();
        chk("rst_grant", 32'(req_read), 32'h0);
        check_outputs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] v;
        logic rdy, fl;
        rst_n = 1'b0; req_valid = '0; req_rob_ix = '0; req_data = '0;
        cdb_ready = 1'b1; flush = 1'b0; last_grant = '0;
        for (int n = 0; n < 4; n++) begin fu_tag[n] = '0; fu_data[n] = '0; end
        model_reset();
        #1;
        do_reset();

        // Idle after reset
        for (int i = 0; i < 5; i++) step("idle", 4'b0000, 1'b1, 1'b0);

        // Single FU
        fu_tag[1] = 3'd3; fu_data[1] = 32'h1234;
        step("single", 4'b0010, 1'b1, 1'b0);
        chk("single_grant_lit", 32'(last_grant), 32'h2);
        chk("single_value_lit", cdb_value, 32'h1234);
        chk("single_src_lit", 32'(cdb_src), 32'd1);
        step("single_idle", 4'b0000, 1'b1, 1'b0);

        // Round-robin from pointer 0
        do_reset();
        for (int n = 0; n < 4; n++) begin fu_tag[n] = 3'(n + 4); fu_data[n] = 32'hA0 + n; end
        for (int i = 0; i < 8; i++) begin
            step("rr", 4'b1111, 1'b1, 1'b0);
            chk("rr_order", 32'(last_grant), 32'(1 << (i % 4)));
        end

        // Stall holding tag 5
        fu_tag[2] = 3'd5; fu_data[2] = 32'h5555;
        step("stall_load", 4'b0100, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("stall", 4'b1001, 1'b0, 1'b0);
            chk("stall_tag_lit", 32'(cdb_rob_ix), 32'd5);
        end
        step("stall_release", 4'b1001, 1'b1, 1'b0);
        step("stall_drain", 4'b0001, 1'b1, 1'b0);

        // Flush with FU2 pending over a valid bus
        fu_tag[1] = 3'd1; fu_data[1] = 32'h111;
        step("fl_load", 4'b0010, 1'b1, 1'b0);
        step("flush", 4'b0100, 1'b1, 1'b1);
        chk("flush_valid_lit", 32'(cdb_valid), 32'h0);
        step("flush_after", 4'b0100, 1'b1, 1'b0);
        chk("flush_after_grant", 32'(last_grant), 32'h4);

        // Reset during a stall discards the pending broadcast
        step("mid_load", 4'b0001, 1'b1, 1'b0);
        step("mid_stall", 4'b0010, 1'b0, 1'b0);
        do_reset();

        // Conflict counter scenario
        step("perf_a", 4'b1001, 1'b1, 1'b0);
        step("perf_b", 4'b1000, 1'b0, 1'b0);
        step("perf_c", 4'b1000, 1'b0, 1'b0);
`ifdef CDB_PERF_EN
        chk("perf_cnt_lit", conflict_cnt, 32'd3);
`endif
        step("perf_d", 4'b1000, 1'b1, 1'b0);

        // Randomized: FUs hold results until read, then may produce new ones
        v = '0;
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < 4; n++) begin
                if (!v[n] && $urandom_range(0, 2) == 0) begin
                    v[n] = 1'b1;
                    fu_tag[n] = 3'($urandom);
                    fu_data[n] = $urandom;
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            step("rand", v, rdy, fl);
            v = v & ~last_grant;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
